// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the unified RAM data port: round-robin with optional
// lock bursts bounded by MAX_HOLD, and a registered read-return path per master.
module ram_port_arbiter #(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned INIT_OWNER = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_mask,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_mask,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] ram_a,
    output logic [31:0] ram_di,
    output logic [3:0]  ram_m,
    output logic        ram_we,
    input  logic [31:0] ram_do
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN_M0 = 2'd1,
        ST_OWN_M1 = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic               r_last_gnt;
    logic               w_last_nxt;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_hold_ok;
    logic               w_keep0;
    logic               w_keep1;

    // State, hold counter and round-robin pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_last_gnt <= (INIT_OWNER == 0) ? 1'b1 : 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_last_gnt <= w_last_nxt;
        end
    end

    // Grant decision; an unrecognised state encoding grants no lock and falls back to IDLE
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
        w_last_nxt  = r_last_gnt;
        w_keep0     = 1'b0;
        w_keep1     = 1'b0;
        w_hold_ok   = (r_hold_cnt < HOLD_W'(MAX_HOLD));

        case (r_state)
            ST_OWN_M0: w_keep0 = m0_lock && w_hold_ok;
            ST_OWN_M1: w_keep1 = m1_lock && w_hold_ok;
            default:   ;
        endcase

        if (reset) begin
            if (m0_req && m1_req) begin
                if (w_keep0) begin
                    w_gnt0     = 1'b1;
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end else if (w_keep1) begin
                    w_gnt1     = 1'b1;
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end else if (r_last_gnt) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else if (m0_req) begin
                w_gnt0 = 1'b1;
            end else if (m1_req) begin
                w_gnt1 = 1'b1;
            end

            if (w_gnt0) begin
                w_state_nxt = ST_OWN_M0;
                w_last_nxt  = 1'b0;
            end else if (w_gnt1) begin
                w_state_nxt = ST_OWN_M1;
                w_last_nxt  = 1'b1;
            end
        end
    end

    assign m0_gnt = w_gnt0;
    assign m1_gnt = w_gnt1;

    // With no grant the port idles on M0's request fields with writes disabled
    assign ram_a  = w_gnt1 ? m1_addr  : m0_addr;
    assign ram_di = w_gnt1 ? m1_wdata : m0_wdata;
    assign ram_m  = w_gnt1 ? m1_mask  : m0_mask;
    assign ram_we = (w_gnt0 && m0_we) || (w_gnt1 && m1_we);

    // Read return: data captured at the grant edge, valid for exactly one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= w_gnt0 && !m0_we;
            m1_rvalid <= w_gnt1 && !m1_we;
            if (w_gnt0 && !m0_we) begin
                m0_rdata <= ram_do;
            end
            if (w_gnt1 && !m1_we) begin
                m1_rdata <= ram_do;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small byte-masked RAM model on the data port.
module tb_ram_port_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_mask;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_mask;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic [31:0] ram_a, ram_di, ram_do;
    logic [3:0]  ram_m;
    logic        ram_we;

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    ram_port_arbiter #(.MAX_HOLD(16), .INIT_OWNER(0)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_mask(m0_mask), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_mask(m1_mask), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_a(ram_a), .ram_di(ram_di), .ram_m(ram_m), .ram_we(ram_we), .ram_do(ram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, byte-masked write at the clock edge
    assign ram_do = mem[ram_a[9:2]];
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_m[b]) mem[ram_a[9:2]][8*b +: 8] <= ram_di[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_gnt;
    logic       g0, g1, pend0;
    int         i1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[32'h10 >> 2] = 32'hDEADBEEF;
        mem[32'h20 >> 2] = 32'h55667788;
        mem[32'h30 >> 2] = 32'h11223344;
        mem[32'h50 >> 2] = 32'h00000000;

        // Reset with both masters requesting; M1 presents a write to 0x20
        reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'h10;
        m0_wdata = 32'h0; m0_mask = 4'hF;
        m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b0; m1_addr = 32'h20;
        m1_wdata = 32'h0; m1_mask = 4'hF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
            check("rst_ram_we", 32'(ram_we), 32'd0);
            edge_step();
            check("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
            check("rst_rdata0", m0_rdata, 32'd0);
            check("rst_rdata1", m1_rdata, 32'd0);
        end
        check("rst_mem20", mem[32'h20 >> 2], 32'h55667788);

        // Contended reads without lock alternate, M0 first
        reset = 1'b1;
        m1_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            check("rr_gnt", 32'({m1_gnt, m0_gnt}), 32'(exp_gnt));
            edge_step();
            check("rr_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'(exp_gnt));
            if (exp_gnt[0]) check("rr_rdata0", m0_rdata, 32'hDEADBEEF);
            else            check("rr_rdata1", m1_rdata, 32'h55667788);
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // Single M0 read, latency one
        edge_step();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        @(negedge clk);
        check("rd_gnt", 32'({m1_gnt, m0_gnt}), 32'b01);
        check("rd_ram_a", ram_a, 32'h10);
        check("rd_ram_we", 32'(ram_we), 32'd0);
        edge_step();
        m0_req = 1'b0;
        check("rd_rvalid", 32'(m0_rvalid), 32'd1);
        check("rd_rdata", m0_rdata, 32'hDEADBEEF);
        edge_step();
        check("rd_rvalid_drop", 32'(m0_rvalid), 32'd0);
        check("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // M1 locked 20-write burst against a held M0 read: 17 M1, 1 M0, 3 M1
        i1 = 0; pend0 = 1'b1;
        m1_we = 1'b1; m1_lock = 1'b1; m1_mask = 4'hF;
        m0_addr = 32'h10; m0_we = 1'b0;
        for (int c = 0; c < 21; c++) begin
            m1_req   = (i1 < 20);
            m1_addr  = 32'h40 + 32'(4 * i1);
            m1_wdata = 32'(i1) + 32'h100;
            m0_req   = pend0;
            exp_gnt  = (c == 17) ? 2'b01 : 2'b10;
            @(negedge clk);
            g0 = m0_gnt; g1 = m1_gnt;
            check("lock_gnt", 32'({g1, g0}), 32'(exp_gnt));
            edge_step();
            if (g1) i1++;
            if (g0) begin
                pend0 = 1'b0;
                check("lock_rvalid0", 32'(m0_rvalid), 32'd1);
                check("lock_rdata0", m0_rdata, 32'hDEADBEEF);
            end
        end
        m1_req = 1'b0; m1_lock = 1'b0; m0_req = 1'b0;
        check("lock_count", 32'(i1), 32'd20);
        check("lock_mem_first", mem[32'h40 >> 2], 32'h100);
        check("lock_mem_last", mem[(32'h40 >> 2) + 19], 32'h113);

        // Byte-masked write by M1 then read-back by M0
        edge_step();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h30; m1_wdata = 32'hAABBCCDD; m1_mask = 4'b0011;
        @(negedge clk);
        check("mask_gnt", 32'({m1_gnt, m0_gnt}), 32'b10);
        check("mask_ram_we", 32'(ram_we), 32'd1);
        check("mask_ram_m", 32'(ram_m), 32'b0011);
        edge_step();
        m1_req = 1'b0;
        check("mask_no_rvalid", 32'(m1_rvalid), 32'd0);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h30;
        @(negedge clk);
        check("mask_rd_gnt", 32'({m1_gnt, m0_gnt}), 32'b01);
        edge_step();
        m0_req = 1'b0;
        check("mask_rdata", m0_rdata, 32'h1122CCDD);

        // Same-address read/write collision: M1 wins (M0 went last), M0 retries and sees new word
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h50;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h50; m1_wdata = 32'hCAFEF00D; m1_mask = 4'hF;
        @(negedge clk);
        check("coll_gnt1", 32'({m1_gnt, m0_gnt}), 32'b10);
        edge_step();
        m1_req = 1'b0;
        check("coll_no_rvalid", 32'(m0_rvalid), 32'd0);
        @(negedge clk);
        check("coll_gnt0", 32'({m1_gnt, m0_gnt}), 32'b01);
        edge_step();
        m0_req = 1'b0;
        check("coll_rdata", m0_rdata, 32'hCAFEF00D);

        // Reset asserted in the cycle an M1 write of 0 to 0x20 would be granted
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h0; m1_mask = 4'hF;
        reset = 1'b0;
        @(negedge clk);
        check("rstw_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        check("rstw_ram_we", 32'(ram_we), 32'd0);
        edge_step();
        m1_req = 1'b0; reset = 1'b1;
        check("rstw_rdata0", m0_rdata, 32'd0);
        edge_step();
        check("rstw_mem20", mem[32'h20 >> 2], 32'h55667788);
        check("rstw_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
